// File: rtl/sorted_seq_reader_if.sv
// sorted_seq_reader_if
//   Output beat stream from sorted_seq_reader to bit_len_gen.
//   out_valid : beat valid (master -> slave)
//   out_ready : slave accepts beat (slave -> master)
//   out_data  : LANES*DATA_W bits, lane 0 in the MSBs
//   out_keep  : lane enables, bit LANES-1 = lane 0, thermometer from the MSB
//   out_last  : final beat of the sequence
interface sorted_seq_reader_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 4
) ();
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out_data;
    logic [LANES-1:0]        out_keep;
    logic                    out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_keep,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_keep,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sorted_seq_reader.sv
// sorted_seq_reader
//   Holds a strictly ordered sequence written by the sorter and, after a commit,
//   streams it out either ascending (LANES elements per beat) or descending
//   (one element per beat, in lane 0).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   wr_en/addr/data : element write port (dropped while reading)
//   load_commit     : latch min(load_count, DEPTH) as the sequence length
//   rd_start        : begin readout, rd_mode 0 = ascending, 1 = descending
//   rd_abort        : stop readout and flush the output
//   out_bus         : valid/ready beat stream (master side)
//   busy            : readout in progress
//   loaded          : a committed sequence is present
//   wr_err          : sticky, write/commit/start rejected; cleared by a commit
module sorted_seq_reader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned LANES  = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                load_commit,
    input  logic [AW:0]         load_count,
    input  logic                rd_start,
    input  logic                rd_mode,
    input  logic                rd_abort,
    sorted_seq_reader_if.master out_bus,
    output logic                busy,
    output logic                loaded,
    output logic                wr_err
);

    localparam int unsigned CW   = AW + 1;
    localparam int unsigned LB   = $clog2(LANES);
    localparam int unsigned ROWS = DEPTH / LANES;
    localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned SW   = (LB > 0) ? LB : 1;

    localparam logic [LANES-1:0] KeepAll   = '1;
    localparam logic [LANES-1:0] KeepLane0 = LANES'(1) << (LANES - 1);

    typedef enum logic [1:0] {StIdle, StReady, StRd} state_e;

    state_e                  state_q;
    logic [CW-1:0]           count_q;
    logic                    mode_q;
    logic [CW-1:0]           iss_ptr_q;   // next element index to read
    logic [CW-1:0]           iss_left_q;  // beats still to be issued
    logic                    m_valid_q;   // RAM output stage holds a beat
    logic [LANES-1:0]        m_keep_q;
    logic                    m_last_q;
    logic [SW-1:0]           m_sel_q;     // bank holding the descending element
    logic                    out_valid_q;
    logic [LANES*DATA_W-1:0] out_data_q;
    logic [LANES-1:0]        out_keep_q;
    logic                    out_last_q;
    logic                    busy_q;
    logic                    loaded_q;
    logic                    wr_err_q;

    logic [CW-1:0]                 rem;
    logic [CW-1:0]                 clamp_count;
    logic [CW-1:0]                 beats_asc;
    logic [LANES-1:0]              iss_keep;
    logic [SW-1:0]                 iss_sel;
    logic [RW-1:0]                 rd_row;
    logic [RW-1:0]                 wr_row;
    logic [SW-1:0]                 wr_bank;
    logic                          adv;
    logic                          issue;
    logic                          xfer_last;
    logic                          wr_ok;
    logic [LANES-1:0][DATA_W-1:0]  bank_rd;
    logic [LANES*DATA_W-1:0]       m_data;

    always_comb begin
        rem = count_q - iss_ptr_q;
        if (mode_q) begin
            iss_keep = (count_q == '0) ? '0 : KeepLane0;
        end else if (rem >= CW'(LANES)) begin
            iss_keep = KeepAll;
        end else begin
            iss_keep = ~(KeepAll >> rem);
        end
        iss_sel     = SW'(iss_ptr_q & CW'(LANES - 1));
        rd_row      = RW'(iss_ptr_q >> LB);
        wr_row      = RW'(wr_addr >> LB);
        wr_bank     = SW'(wr_addr & AW'(LANES - 1));
        clamp_count = (load_count > CW'(DEPTH)) ? CW'(DEPTH) : load_count;
        beats_asc   = CW'((32'(count_q) + LANES - 1) >> LB);
        wr_ok       = wr_en && (state_q != StRd);
        // RAM output stage moves into the output register when that is free or draining.
        adv         = (state_q == StRd) && m_valid_q && (!out_valid_q || out_bus.out_ready);
        // A new read is issued only when the RAM output stage will be empty next cycle,
        // so a stall freezes the bank read registers and nothing is lost.
        issue       = (state_q == StRd) && !rd_abort && (iss_left_q != '0) &&
                      (!m_valid_q || adv);
        xfer_last   = out_valid_q && out_bus.out_ready && out_last_q;
    end

    // Lane formatting of the RAM output stage; unused lanes are forced to zero.
    always_comb begin
        m_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (m_keep_q[LANES-1-i]) begin
                m_data[(LANES-1-i)*DATA_W +: DATA_W] = mode_q ? bank_rd[m_sel_q] : bank_rd[i];
            end
        end
    end

    // One bank per lane; an ascending beat reads the same row from every bank.
    for (genvar b = 0; b < LANES; b++) begin : g_bank
        logic [DATA_W-1:0] mem [ROWS];
        logic [DATA_W-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (wr_ok && (wr_bank == SW'(b))) begin
                mem[wr_row] <= wr_data;
            end
            if (issue) begin
                rd_q <= mem[rd_row];
            end
        end

        assign bank_rd[b] = rd_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            mode_q      <= 1'b0;
            iss_ptr_q   <= '0;
            iss_left_q  <= '0;
            m_valid_q   <= 1'b0;
            m_keep_q    <= '0;
            m_last_q    <= 1'b0;
            m_sel_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            loaded_q    <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StReady: begin
                    // A commit takes priority over a start in the same cycle.
                    if (load_commit) begin
                        count_q  <= clamp_count;
                        wr_err_q <= 1'b0;
                        loaded_q <= 1'b1;
                        state_q  <= StReady;
                    end else if (rd_start && !rd_abort) begin
                        if (state_q == StIdle) begin
                            wr_err_q <= 1'b1;
                        end else begin
                            state_q <= StRd;
                            busy_q  <= 1'b1;
                            mode_q  <= rd_mode;
                            if (rd_mode) begin
                                iss_ptr_q  <= (count_q == '0) ? '0 : count_q - CW'(1);
                                iss_left_q <= (count_q == '0) ? CW'(1) : count_q;
                            end else begin
                                iss_ptr_q  <= '0;
                                iss_left_q <= (count_q == '0) ? CW'(1) : beats_asc;
                            end
                        end
                    end
                end
                StRd: begin
                    if (wr_en || load_commit) begin
                        wr_err_q <= 1'b1;
                    end
                    if (rd_abort) begin
                        state_q     <= StReady;
                        busy_q      <= 1'b0;
                        iss_left_q  <= '0;
                        m_valid_q   <= 1'b0;
                        out_valid_q <= 1'b0;
                        out_data_q  <= '0;
                        out_keep_q  <= '0;
                        out_last_q  <= 1'b0;
                    end else begin
                        if (issue) begin
                            m_valid_q  <= 1'b1;
                            m_keep_q   <= iss_keep;
                            m_last_q   <= (iss_left_q == CW'(1));
                            m_sel_q    <= iss_sel;
                            iss_ptr_q  <= mode_q ? iss_ptr_q - CW'(1) : iss_ptr_q + CW'(LANES);
                            iss_left_q <= iss_left_q - CW'(1);
                        end else if (adv) begin
                            m_valid_q <= 1'b0;
                        end
                        if (adv) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= m_data;
                            out_keep_q  <= m_keep_q;
                            out_last_q  <= m_last_q;
                        end else if (out_valid_q && out_bus.out_ready) begin
                            out_valid_q <= 1'b0;
                        end
                        if (xfer_last) begin
                            state_q <= StReady;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign out_bus.out_valid = out_valid_q;
    assign out_bus.out_data  = out_data_q;
    assign out_bus.out_keep  = out_keep_q;
    assign out_bus.out_last  = out_last_q;
    assign busy              = busy_q;
    assign loaded            = loaded_q;
    assign wr_err            = wr_err_q;

endmodule

// File: tb/tb_sorted_seq_reader.sv
// tb_sorted_seq_reader
//   Directed bench for sorted_seq_reader (DATA_W=8, DEPTH=256, LANES=4).
//   Memory holds element i = i; a table of read scenarios is applied in a loop,
//   followed by hand sequences for write-during-read, abort and reset.
module tb_sorted_seq_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       load_commit;
    logic [8:0] load_count;
    logic       rd_start;
    logic       rd_mode;
    logic       rd_abort;
    logic       out_ready;
    logic       busy;
    logic       loaded;
    logic       wr_err;

    sorted_seq_reader_if #(.DATA_W(8), .LANES(4)) bus ();
    assign bus.out_ready = out_ready;

    sorted_seq_reader #(.DATA_W(8), .DEPTH(256), .LANES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .load_commit (load_commit),
        .load_count  (load_count),
        .rd_start    (rd_start),
        .rd_mode     (rd_mode),
        .rd_abort    (rd_abort),
        .out_bus     (bus),
        .busy        (busy),
        .loaded      (loaded),
        .wr_err      (wr_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit         commit;
        int         cnt;
        bit         mode;
        int         pat;      // 0 = ready always, 1 = toggling, 2 = random
        int         beats;
        logic [31:0] first_d;
        logic [3:0]  first_k;
        logic [31:0] last_d;
        logic [3:0]  last_k;
    } vec_t;

    localparam int MaxCyc = 2000;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          model_cnt = 0;
    logic [31:0] beat_data [0:511];
    logic [3:0]  beat_keep [0:511];
    logic        beat_last [0:511];
    int          n_beats;
    int          first_valid;
    int          last_xfer;
    int          unstable;
    bit          timed_out;
    logic        busy_after;
    logic        valid_after;
    logic        loaded_after;
    vec_t        vecs [0:11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit ready_pat(input int pat, input int cyc);
        case (pat)
            0:       return 1'b1;
            1:       return (cyc % 2) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Element e holds value e, so the expected beat follows from indices alone.
    function automatic logic [31:0] model_data(input int k, input bit mode, input int cnt);
        logic [31:0] d;
        int e;
        d = '0;
        if (!mode) begin
            for (int i = 0; i < 4; i++) begin
                e = k * 4 + i;
                if (e < cnt) d[(3-i)*8 +: 8] = e[7:0];
            end
        end else if (cnt > 0) begin
            e = cnt - 1 - k;
            d[31:24] = e[7:0];
        end
        return d;
    endfunction

    function automatic logic [3:0] model_keep(input int k, input bit mode, input int cnt);
        logic [3:0] kp;
        kp = '0;
        if (!mode) begin
            for (int i = 0; i < 4; i++) if (k * 4 + i < cnt) kp[3-i] = 1'b1;
        end else if (cnt > 0) begin
            kp = 4'b1000;
        end
        return kp;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = addr[7:0];
        wr_data = data[7:0];
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_commit(input int cnt);
        load_commit = 1'b1;
        load_count  = cnt[8:0];
        step();
        load_commit = 1'b0;
        model_cnt   = (cnt > 256) ? 256 : cnt;
    endtask

    // Pulses rd_start and collects beats until out_last transfers or the budget expires.
    task automatic run_read(input bit mode, input int pat);
        int   cyc;
        bit   done;
        bit   rdy;
        bit   prev_stall;
        logic [31:0] prev_d;
        logic [3:0]  prev_k;
        logic        prev_l;
        n_beats = 0; first_valid = -1; last_xfer = -1; unstable = 0;
        done = 1'b0; prev_stall = 1'b0; prev_d = '0; prev_k = '0; prev_l = 1'b0;
        rd_start = 1'b1;
        rd_mode  = mode;
        step();
        rd_start = 1'b0;
        rd_mode  = ~mode;  // mode must have been captured on the start cycle
        cyc = 0;
        while (!done && cyc < MaxCyc) begin
            rdy = ready_pat(pat, cyc);
            out_ready = rdy;
            @(negedge clk);
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_d ||
                               bus.out_keep !== prev_k || bus.out_last !== prev_l)) begin
                unstable++;
            end
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (bus.out_valid && rdy) begin
                if (n_beats < 512) begin
                    beat_data[n_beats] = bus.out_data;
                    beat_keep[n_beats] = bus.out_keep;
                    beat_last[n_beats] = bus.out_last;
                end
                n_beats++;
                if (bus.out_last) begin
                    done = 1'b1;
                    last_xfer = cyc;
                end
            end
            prev_stall = bus.out_valid && !rdy;
            prev_d = bus.out_data;
            prev_k = bus.out_keep;
            prev_l = bus.out_last;
            step();
            cyc++;
        end
        timed_out = !done;
        out_ready = 1'b0;
        @(negedge clk);
        busy_after   = busy;
        valid_after  = bus.out_valid;
        loaded_after = loaded;
        step();
    endtask

    task automatic apply_vec(input vec_t v, input int id);
        int errs;
        int last;
        if (v.commit) do_commit(v.cnt);
        run_read(v.mode, v.pat);
        last = (n_beats > 0) ? ((n_beats > 512) ? 511 : n_beats - 1) : 0;
        check($sformatf("v%0d timeout", id), 64'(timed_out), 64'(0));
        check($sformatf("v%0d beats", id), 64'(n_beats), 64'(v.beats));
        check($sformatf("v%0d first_data", id), 64'(beat_data[0]), 64'(v.first_d));
        check($sformatf("v%0d first_keep", id), 64'(beat_keep[0]), 64'(v.first_k));
        check($sformatf("v%0d last_data", id), 64'(beat_data[last]), 64'(v.last_d));
        check($sformatf("v%0d last_keep", id), 64'(beat_keep[last]), 64'(v.last_k));
        check($sformatf("v%0d latency", id), 64'(first_valid), 64'(2));
        check($sformatf("v%0d stall_stable", id), 64'(unstable), 64'(0));
        errs = 0;
        for (int k = 0; k < n_beats && k < 512; k++) begin
            if (beat_data[k] !== model_data(k, v.mode, model_cnt) ||
                beat_keep[k] !== model_keep(k, v.mode, model_cnt) ||
                beat_last[k] !== (k == n_beats - 1)) begin
                errs++;
            end
        end
        check($sformatf("v%0d beat_model", id), 64'(errs), 64'(0));
        if (v.pat == 0) begin
            check($sformatf("v%0d no_bubble", id), 64'(last_xfer - first_valid + 1),
                  64'(n_beats));
        end
        check($sformatf("v%0d busy_after", id), 64'(busy_after), 64'(0));
        check($sformatf("v%0d valid_after", id), 64'(valid_after), 64'(0));
        check($sformatf("v%0d loaded_after", id), 64'(loaded_after), 64'(1));
    endtask

    task automatic count_quiet(input int ncyc, output int hits);
        hits = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (bus.out_valid || busy) hits++;
            step();
        end
    endtask

    initial begin
        int   xfers;
        int   cyc;
        int   hits;
        vec_t v;

        vecs[0]  = '{1'b1, 256, 1'b0, 0,  64, 32'h00010203, 4'b1111, 32'hFCFDFEFF, 4'b1111};
        vecs[1]  = '{1'b1,  10, 1'b0, 0,   3, 32'h00010203, 4'b1111, 32'h08090000, 4'b1100};
        vecs[2]  = '{1'b1,   5, 1'b1, 0,   5, 32'h04000000, 4'b1000, 32'h00000000, 4'b1000};
        vecs[3]  = '{1'b0,   5, 1'b1, 0,   5, 32'h04000000, 4'b1000, 32'h00000000, 4'b1000};
        vecs[4]  = '{1'b1, 256, 1'b0, 1,  64, 32'h00010203, 4'b1111, 32'hFCFDFEFF, 4'b1111};
        vecs[5]  = '{1'b0, 256, 1'b0, 2,  64, 32'h00010203, 4'b1111, 32'hFCFDFEFF, 4'b1111};
        vecs[6]  = '{1'b1,   1, 1'b0, 0,   1, 32'h00000000, 4'b1000, 32'h00000000, 4'b1000};
        vecs[7]  = '{1'b1,   7, 1'b1, 1,   7, 32'h06000000, 4'b1000, 32'h00000000, 4'b1000};
        vecs[8]  = '{1'b1, 255, 1'b0, 2,  64, 32'h00010203, 4'b1111, 32'hFCFDFE00, 4'b1110};
        vecs[9]  = '{1'b1,   0, 1'b0, 0,   1, 32'h00000000, 4'b0000, 32'h00000000, 4'b0000};
        vecs[10] = '{1'b0,   0, 1'b1, 0,   1, 32'h00000000, 4'b0000, 32'h00000000, 4'b0000};
        vecs[11] = '{1'b1, 300, 1'b1, 1, 256, 32'hFF000000, 4'b1000, 32'h00000000, 4'b1000};

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; load_commit = 1'b0;
        load_count = '0; rd_start = 1'b0; rd_mode = 1'b0; rd_abort = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset outputs", {bus.out_valid, bus.out_data, bus.out_keep, bus.out_last,
                                busy, loaded, wr_err}, '0);
        step();

        // Start with nothing loaded is rejected.
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        count_quiet(4, hits);
        check("idle start quiet", 64'(hits), 64'(0));
        @(negedge clk);
        check("idle start wr_err", 64'(wr_err), 64'(1));
        step();

        for (int i = 0; i < 256; i++) do_write(i, i);
        @(negedge clk);
        check("writes not loaded", 64'(loaded), 64'(0));
        step();

        for (int n = 0; n < 12; n++) begin
            v = vecs[n];
            apply_vec(v, n);
        end
        @(negedge clk);
        check("commit clears wr_err", 64'(wr_err), 64'(0));
        step();

        // Write and commit during a read are dropped; abort at beat 20.
        do_commit(256);
        rd_start = 1'b1;
        rd_mode  = 1'b0;
        step();
        rd_start = 1'b0;
        out_ready = 1'b1;
        xfers = 0;
        cyc = 0;
        while (xfers < 20 && cyc < 200) begin
            wr_en       = (cyc == 5);
            wr_addr     = 8'd5;
            wr_data     = 8'hAA;
            load_commit = (cyc == 6);
            load_count  = 9'd3;
            @(negedge clk);
            if (bus.out_valid) xfers++;
            step();
            cyc++;
        end
        wr_en = 1'b0;
        load_commit = 1'b0;
        check("rd xfers before abort", 64'(xfers), 64'(20));
        rd_abort  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        check("rd wr_err", 64'(wr_err), 64'(1));
        check("beat20 on bus", {bus.out_valid, bus.out_data}, {1'b1, 32'h50515253});
        step();
        rd_abort  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("abort next cycle", {bus.out_valid, busy, loaded}, 3'b001);
        step();
        count_quiet(5, hits);
        check("abort flushed", 64'(hits), 64'(0));
        v = '{1'b0, 256, 1'b0, 0, 64, 32'h00010203, 4'b1111, 32'hFCFDFEFF, 4'b1111};
        apply_vec(v, 20);
        @(negedge clk);
        check("wr_err sticky", 64'(wr_err), 64'(1));
        step();
        do_commit(256);
        @(negedge clk);
        check("commit clears wr_err 2", 64'(wr_err), 64'(0));
        step();

        // Abort outside a read does nothing; abort with start suppresses the start.
        rd_abort = 1'b1;
        step();
        rd_abort = 1'b0;
        @(negedge clk);
        check("idle abort", {busy, loaded}, 2'b01);
        step();
        rd_abort = 1'b1;
        rd_start = 1'b1;
        step();
        rd_abort = 1'b0;
        rd_start = 1'b0;
        count_quiet(4, hits);
        check("abort beats start", 64'(hits), 64'(0));

        // Reset in the middle of a read.
        rd_start = 1'b1;
        rd_mode  = 1'b0;
        step();
        rd_start = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid reset outputs", {bus.out_valid, bus.out_data, bus.out_keep, bus.out_last,
                                    busy, loaded, wr_err}, '0);
        step();
        count_quiet(4, hits);
        check("mid reset quiet", 64'(hits), 64'(0));
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        count_quiet(4, hits);
        check("post reset start quiet", 64'(hits), 64'(0));
        @(negedge clk);
        check("post reset start wr_err", 64'(wr_err), 64'(1));
        step();
        v = '{1'b1, 0, 1'b0, 0, 1, 32'h00000000, 4'b0000, 32'h00000000, 4'b0000};
        apply_vec(v, 30);
        @(negedge clk);
        check("count0 commit wr_err", 64'(wr_err), 64'(0));
        step();
        v = '{1'b1, 4, 1'b0, 0, 1, 32'h00010203, 4'b1111, 32'h00010203, 4'b1111};
        apply_vec(v, 31);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sorted_seq_reader.md
Name: sorted_seq_reader

Overview:
- Parametrised successor to the two-bank sorted-heap buffer in the Huffman path.
- Holds a strictly ordered sequence (index 0 = minimum), written by the sorter.
- After a commit, streams the sequence to bit_len_gen over a valid/ready interface:
  - ascending mode: LANES elements per beat;
  - descending mode: one element per beat.
- Supports partial fill, re-reads without reload, abort and backpressure.

Parameters:
DATA_W, 8, element width in bits
DEPTH, 256, element capacity (power of 2)
LANES, 4, elements per ascending beat (power of 2, divides DEPTH)
AW, log2(DEPTH), write address / count width (localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_en  in  1  element write strobe
wr_addr  in  AW  element index
wr_data  in  DATA_W  element value
load_commit  in  1  pulse: sequence complete, latch load_count
load_count  in  AW+1  number of valid elements, 0..DEPTH
rd_start  in  1  pulse: begin readout
rd_mode  in  1  0 = ascending multi-lane, 1 = descending single
rd_abort  in  1  pulse: stop readout, flush output
out_valid  out  1  beat valid
out_ready  in  1  consumer accepts beat
out_data  out  LANES*DATA_W  lane 0 in MSBs
out_keep  out  LANES  bit LANES-1 = lane 0; valid lanes form a thermometer from the MSB
out_last  out  1  final beat of the sequence
busy  out  1  readout in progress
loaded  out  1  committed sequence present
wr_err  out  1  sticky: write, commit or start rejected

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - State = IDLE.
  - All outputs = 0.
  - Count and pointers = 0.
  - Memory contents are not cleared.
  - Reset mid-readout aborts immediately; no further beats are produced.
- States:
  - IDLE: not loaded. wr_en is accepted. load_commit -> READY.
  - READY: loaded=1. wr_en is accepted and overwrites data. load_commit re-latches the count. rd_start -> RD.
  - RD: busy=1. Readout is running.
  - After the final beat handshake -> READY. The sequence stays loaded and may be re-read any number of times.
- load_commit:
  - Latches min(load_count, DEPTH).
  - Clears wr_err.
  - Ignored during RD and sets wr_err.
- wr_en during RD: write dropped, wr_err=1.
- rd_start:
  - Ignored in IDLE (sets wr_err) and during RD (no effect).
  - rd_mode is sampled on the rd_start cycle.
- Count 0: rd_start produces exactly one beat with out_keep=0, out_data=0, out_last=1.
- Ascending mode:
  - Beat k carries elements k*LANES .. k*LANES+LANES-1; lane i holds element k*LANES+i.
  - Number of beats = ceil(count/LANES).
  - Last beat: out_keep has the top (count mod LANES, or LANES if 0) bits set; unused lanes are driven 0.
- Descending mode:
  - Beats carry elements count-1 down to 0, one per beat.
  - Element sits in lane 0; out_keep = 1 followed by zeros (MSB set); other lanes are driven 0.
- Latency: rd_start at edge t -> first out_valid=1 after edge t+2 (synchronous RAM read plus output register).
- Throughput: one beat per cycle while out_ready=1; no bubbles after the first beat.
- Handshake:
  - A beat transfers when out_valid & out_ready.
  - While out_valid & !out_ready, out_data, out_keep and out_last hold stable.
  - out_valid never drops without a transfer, except on abort or reset.
  - Internal skid storage is at most 2 beats; no beat is lost or duplicated.
- out_last: high only with the final beat. busy drops the cycle after its transfer.
- rd_abort during RD:
  - Next cycle: out_valid=0, busy=0, state READY.
  - Any in-flight reads are discarded.
  - rd_abort outside RD has no effect.
- Simultaneous events:
  - rd_abort and rd_start together: abort wins, start ignored.
  - rst overrides everything.
- Storage: LANES banks of DEPTH/LANES words each. wr_addr[log2(LANES)-1:0] selects the bank, so an ascending beat is one read from each bank in the same cycle.

Test Plan (DATA_W=8, DEPTH=256, LANES=4):
1. Write element i = i for 0..255; commit count 256; ascending; out_ready=1.
   -> first out_valid 2 cycles after rd_start; 64 consecutive beats.
   -> beat0 = 0x00010203, beat63 = 0xFCFDFEFF with out_last=1; keep=4'b1111 on every beat.
2. Same data; commit count 10; ascending.
   -> 3 beats: 0x00010203, 0x04050607, 0x08090000.
   -> last beat keep=4'b1100, out_last=1; then busy=0, loaded=1.
3. Commit count 5; descending.
   -> 5 beats: 0x04000000, 0x03000000, 0x02000000, 0x01000000, 0x00000000.
   -> keep=4'b1000 on each beat; out_last on the 5th.
   -> Repeat rd_start: identical sequence again without reload.
4. Count 256, ascending, out_ready toggling 1,0,1,0 and random.
   -> data stable through every stall; exactly 64 transfers in order; no duplicates.
5. Write during RD.
   -> wr_err=1, memory unchanged.
   -> rd_abort at beat 20: out_valid=0 next cycle.
   -> New rd_start replays from beat 0.
   -> load_commit clears wr_err.
6. rst asserted mid-readout.
   -> all outputs 0 next cycle; loaded=0.
   -> rd_start ignored with wr_err=1 until a new load_commit; count 0 commit gives a single beat with keep=0, out_last=1.
